eth_type_demux: RTL and testbench
=================================

ETH_TYPE_DEMUX -- requirements
Module: eth_type_demux

Interface
REQ-001 SHALL have parameter M_COUNT, default 4, number of output channels (2..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, payload tdata width.
REQ-003 SHALL have parameter ETH_TYPES, default {16'h86DD,16'h88CC,16'h0806,16'h0800}, M_COUNT*16-bit match table; channel i matches bits [16*i+15:16*i].
REQ-004 SHALL have parameter DEFAULT_EN, default 0: 0 = drop unmatched frames; 1 = route unmatched frames to channel M_COUNT-1.
REQ-005 SHALL have parameter CNT_WIDTH, default 16, drop counter width.
REQ-006 One clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 s_eth_hdr_valid / s_eth_hdr_ready  in / out  1 / 1  input header handshake.
REQ-010 s_eth_dest_mac, s_eth_src_mac, s_eth_type  in  48, 48, 16  input header fields.
REQ-011 s_eth_payload_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  DATA_WIDTH/1/1/1/1  input payload stream.
REQ-012 m_eth_hdr_valid / m_eth_hdr_ready  out / in  M_COUNT / M_COUNT  per-channel header handshake.
REQ-013 m_eth_dest_mac, m_eth_src_mac, m_eth_type  out  48, 48, 16  shared header fields.
REQ-014 m_eth_payload_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  DATA_WIDTH/M_COUNT/M_COUNT/1/1  per-channel valid/ready, shared data/last/user.
REQ-015 chan_enable  in  M_COUNT  per-channel enable; a disabled channel never matches.
REQ-016 drop_count  out  CNT_WIDTH  frames dropped since reset.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 States: IDLE, HDR, PAYLOAD, DROP.
REQ-019 IDLE: s_eth_hdr_ready=1; s_eth_payload_axis_tready=0; on s_eth_hdr_valid, register header fields and select index, then go to HDR if matched, otherwise to DROP.
REQ-020 Select rule: channel = lowest i with s_eth_type==ETH_TYPES[i] and chan_enable[i]=1.
REQ-021 If no channel matches and DEFAULT_EN=1, select M_COUNT-1 regardless of chan_enable; if DEFAULT_EN=0, the frame is unmatched.
REQ-022 HDR: m_eth_hdr_valid[sel]=1 and all other bits 0; header appears one cycle after input acceptance; stay in HDR until m_eth_hdr_ready[sel], then go to PAYLOAD.
REQ-023 Header fields SHALL stay stable while in HDR.
REQ-024 PAYLOAD: combinational pass-through, zero latency.
  - m tvalid[sel] = s tvalid; other tvalid bits 0.
  - s tready = m tready[sel].
  - tdata, tlast and tuser forwarded unchanged.
REQ-025 PAYLOAD to IDLE on the handshake beat with tlast=1.
REQ-026 DROP: s tready=1; all m tvalid=0; consume beats until tlast handshake, then go to IDLE and increment drop_count by 1.
REQ-027 drop_count SHALL saturate at all-ones.
REQ-028 s_eth_hdr_ready=0 in HDR, PAYLOAD and DROP; the next header is accepted no earlier than the cycle after the tlast handshake.
REQ-029 s tready=0 in IDLE and HDR; payload is never consumed before its header is delivered.
REQ-030 chan_enable changes after header acceptance SHALL NOT affect the frame in flight.
REQ-031 tuser=1 frames in PAYLOAD SHALL be forwarded, not dropped.
REQ-032 Single-beat frames (tlast on first beat) SHALL be handled with no extra idle cycle beyond REQ-028.

Reset
REQ-033 rst asserted at any time forces, immediately:
  - state = IDLE;
  - all m_eth_hdr_valid = 0 and all m tvalid = 0;
  - header registers and m_eth_type = 0;
  - drop_count = 0; busy = 0;
  - s tready = 0; s_eth_hdr_ready = 1 after rst deasserts.
REQ-034 A frame interrupted by reset is abandoned; subsequent beats without a new header SHALL NOT be consumed.

Verification
REQ-035 Type 0x0806, all enabled, 5-beat frame -> m_eth_hdr_valid=4'b0010 one cycle after accept; 5 beats on channel 1 only; busy low after tlast.
REQ-036 Type 0x1234, DEFAULT_EN=0 -> no m valid; 3 beats consumed at one per cycle; drop_count 0->1.
REQ-037 Type 0x1234, DEFAULT_EN=1 -> frame on channel 3; drop_count unchanged.
REQ-038 Type 0x0800 with chan_enable=4'b1110 and DEFAULT_EN=0 -> dropped, drop_count +1.
REQ-039 Type 0x0800 with m tready[0] toggling 1,0,1 -> no beat lost or duplicated; s tready mirrors m tready[0].
REQ-040 rst pulsed in PAYLOAD mid-frame -> all outputs reset within the same cycle; leftover beats stalled (s tready=0); next header routed correctly.

Source files
------------

// File: rtl/eth_type_demux.sv
// Routes one Ethernet frame (header + payload stream) to the first enabled output
// channel whose EtherType matches; unmatched frames are dropped or sent to the last channel.
module eth_type_demux #(
   parameter int                    M_COUNT    = 4,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [M_COUNT*16-1:0] ETH_TYPES  = {16'h86DD, 16'h88CC, 16'h0806, 16'h0800},
   parameter bit                    DEFAULT_EN = 1'b0,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  s_eth_hdr_valid,
   output logic                  s_eth_hdr_ready,
   input  logic [47:0]           s_eth_dest_mac,
   input  logic [47:0]           s_eth_src_mac,
   input  logic [15:0]           s_eth_type,
   input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
   input  logic                  s_eth_payload_axis_tvalid,
   output logic                  s_eth_payload_axis_tready,
   input  logic                  s_eth_payload_axis_tlast,
   input  logic                  s_eth_payload_axis_tuser,

   output logic [M_COUNT-1:0]    m_eth_hdr_valid,
   input  logic [M_COUNT-1:0]    m_eth_hdr_ready,
   output logic [47:0]           m_eth_dest_mac,
   output logic [47:0]           m_eth_src_mac,
   output logic [15:0]           m_eth_type,
   output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
   output logic [M_COUNT-1:0]    m_eth_payload_axis_tvalid,
   input  logic [M_COUNT-1:0]    m_eth_payload_axis_tready,
   output logic                  m_eth_payload_axis_tlast,
   output logic                  m_eth_payload_axis_tuser,

   input  logic [M_COUNT-1:0]    chan_enable,
   output logic [CNT_WIDTH-1:0]  drop_count,
   output logic                  busy
);

   localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [SEL_W-1:0]     r_sel;
   logic [SEL_W-1:0]     w_match_sel;
   logic                 w_matched;
   logic [47:0]          r_dest_mac;
   logic [47:0]          r_src_mac;
   logic [15:0]          r_type;
   logic [CNT_WIDTH-1:0] r_drop_count;
   logic                 w_hdr_accept;
   logic                 w_drop_done;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Scan from the top down so the lowest matching enabled channel wins.
   always_comb begin
      w_matched   = 1'b0;
      w_match_sel = '0;
      for (int i = M_COUNT-1; i >= 0; i--) begin
         if (chan_enable[i] && (s_eth_type == ETH_TYPES[16*i +: 16])) begin
            w_matched   = 1'b1;
            w_match_sel = SEL_W'(i);
         end
      end
      if (!w_matched && DEFAULT_EN) begin
         w_matched   = 1'b1;
         w_match_sel = SEL_W'(M_COUNT-1);
      end
   end

   always_comb begin
      w_state_next              = r_state;
      s_eth_hdr_ready           = 1'b0;
      s_eth_payload_axis_tready = 1'b0;
      m_eth_hdr_valid           = '0;
      m_eth_payload_axis_tvalid = '0;
      case (r_state)
         IDLE: begin
            s_eth_hdr_ready = ~rst;
            if (s_eth_hdr_valid)
               w_state_next = w_matched ? HDR : DROP;
         end
         HDR: begin
            m_eth_hdr_valid[r_sel] = 1'b1;
            if (m_eth_hdr_ready[r_sel])
               w_state_next = PAYLOAD;
         end
         PAYLOAD: begin
            m_eth_payload_axis_tvalid[r_sel] = s_eth_payload_axis_tvalid;
            s_eth_payload_axis_tready        = m_eth_payload_axis_tready[r_sel];
            if (s_eth_payload_axis_tvalid && m_eth_payload_axis_tready[r_sel] &&
                s_eth_payload_axis_tlast)
               w_state_next = IDLE;
         end
         DROP: begin
            s_eth_payload_axis_tready = 1'b1;
            if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast)
               w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_hdr_accept = (r_state == IDLE) && s_eth_hdr_valid;
   assign w_drop_done  = (r_state == DROP) && s_eth_payload_axis_tvalid && s_eth_payload_axis_tlast;

   // Select index and header are captured once at acceptance, so later enable changes are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_sel        <= '0;
         r_dest_mac   <= '0;
         r_src_mac    <= '0;
         r_type       <= '0;
         r_drop_count <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_hdr_accept) begin
            r_sel      <= w_match_sel;
            r_dest_mac <= s_eth_dest_mac;
            r_src_mac  <= s_eth_src_mac;
            r_type     <= s_eth_type;
         end
         if (w_drop_done)
            r_drop_count <= sat_inc(r_drop_count);
      end
   end

   assign m_eth_dest_mac           = r_dest_mac;
   assign m_eth_src_mac            = r_src_mac;
   assign m_eth_type               = r_type;
   assign m_eth_payload_axis_tdata = s_eth_payload_axis_tdata;
   assign m_eth_payload_axis_tlast = s_eth_payload_axis_tlast;
   assign m_eth_payload_axis_tuser = s_eth_payload_axis_tuser;
   assign drop_count               = r_drop_count;
   assign busy                     = (r_state != IDLE);

endmodule

// File: tb/tb_eth_type_demux.sv
// Bench for eth_type_demux: two instances (drop mode with a narrow counter, default-route mode)
// driven by directed and random frames, checked against a table-lookup routing model.
module tb_eth_type_demux;

   localparam int CW0 = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        hv[2], hr[2], sv[2], sr[2], sl[2], su[2], ml[2], mu[2], bz[2];
   logic [47:0] dmac[2], smac[2], mdm[2], msm[2];
   logic [15:0] ty[2], mty[2];
   logic [7:0]  sd[2], md[2];
   logic [3:0]  mhv[2], mhr[2], mv[2], mr[2], en[2];
   logic [CW0-1:0] dc0;
   logic [15:0]    dc1;

   int n_chk = 0;
   int n_pass = 0;
   int mdc[2];
   logic [15:0] tbl[4] = '{16'h0800, 16'h0806, 16'h88CC, 16'h86DD};

   eth_type_demux #(.M_COUNT(4), .DATA_WIDTH(8), .DEFAULT_EN(1'b0), .CNT_WIDTH(CW0)) u_drop (
      .clk(clk), .rst(rst),
      .s_eth_hdr_valid(hv[0]), .s_eth_hdr_ready(hr[0]),
      .s_eth_dest_mac(dmac[0]), .s_eth_src_mac(smac[0]), .s_eth_type(ty[0]),
      .s_eth_payload_axis_tdata(sd[0]), .s_eth_payload_axis_tvalid(sv[0]),
      .s_eth_payload_axis_tready(sr[0]), .s_eth_payload_axis_tlast(sl[0]),
      .s_eth_payload_axis_tuser(su[0]),
      .m_eth_hdr_valid(mhv[0]), .m_eth_hdr_ready(mhr[0]),
      .m_eth_dest_mac(mdm[0]), .m_eth_src_mac(msm[0]), .m_eth_type(mty[0]),
      .m_eth_payload_axis_tdata(md[0]), .m_eth_payload_axis_tvalid(mv[0]),
      .m_eth_payload_axis_tready(mr[0]), .m_eth_payload_axis_tlast(ml[0]),
      .m_eth_payload_axis_tuser(mu[0]),
      .chan_enable(en[0]), .drop_count(dc0), .busy(bz[0])
   );

   eth_type_demux #(.M_COUNT(4), .DATA_WIDTH(8), .DEFAULT_EN(1'b1), .CNT_WIDTH(16)) u_dflt (
      .clk(clk), .rst(rst),
      .s_eth_hdr_valid(hv[1]), .s_eth_hdr_ready(hr[1]),
      .s_eth_dest_mac(dmac[1]), .s_eth_src_mac(smac[1]), .s_eth_type(ty[1]),
      .s_eth_payload_axis_tdata(sd[1]), .s_eth_payload_axis_tvalid(sv[1]),
      .s_eth_payload_axis_tready(sr[1]), .s_eth_payload_axis_tlast(sl[1]),
      .s_eth_payload_axis_tuser(su[1]),
      .m_eth_hdr_valid(mhv[1]), .m_eth_hdr_ready(mhr[1]),
      .m_eth_dest_mac(mdm[1]), .m_eth_src_mac(msm[1]), .m_eth_type(mty[1]),
      .m_eth_payload_axis_tdata(md[1]), .m_eth_payload_axis_tvalid(mv[1]),
      .m_eth_payload_axis_tready(mr[1]), .m_eth_payload_axis_tlast(ml[1]),
      .m_eth_payload_axis_tuser(mu[1]),
      .chan_enable(en[1]), .drop_count(dc1), .busy(bz[1])
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Routing model: first enabled table hit, else last channel (default mode) or drop (-1).
   function automatic int model_sel(input int d, input logic [15:0] t, input logic [3:0] e);
      for (int i = 0; i < 4; i++)
         if (t == tbl[i] && e[i]) return i;
      return (d == 1) ? 3 : -1;
   endfunction

   function automatic logic [15:0] get_dc(input int d);
      return (d == 0) ? 16'(dc0) : dc1;
   endfunction

   function automatic logic [15:0] pick_type();
      int r;
      r = $urandom_range(0, 5);
      if (r < 4) return tbl[r];
      if (r == 4) return 16'h1234;
      return 16'($urandom);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: always valid/ready; 1: random gaps and backpressure; 2: ready toggles 1,0,1...
   task automatic run_frame(input int d, input logic [15:0] t, input logic [3:0] e,
                            input int len, input int mode);
      int          ch, k, cyc, waits, cmax;
      logic [3:0]  oh;
      logic [7:0]  data[8];
      logic [47:0] dm, sm;
      logic        v;
      ch   = model_sel(d, t, e);
      oh   = (ch >= 0) ? 4'(1 << ch) : 4'b0;
      cmax = (d == 0) ? ((1 << CW0) - 1) : 65535;
      for (int i = 0; i < len; i++) data[i] = 8'($urandom);
      dm = {16'($urandom), 32'($urandom)};
      sm = {16'($urandom), 32'($urandom)};
      hv[d] = 1'b1; ty[d] = t; dmac[d] = dm; smac[d] = sm; en[d] = e;
      sv[d] = 1'b0; mhr[d] = 4'b0;
      #1;
      chk("idle_hdr_ready", 64'(hr[d]), 64'd1);
      chk("idle_busy", 64'(bz[d]), 64'd0);
      tick();
      hv[d] = 1'b0; ty[d] = 16'($urandom); dmac[d] = 48'($urandom); en[d] = 4'($urandom);
      if (ch >= 0) begin
         sv[d] = 1'b1; sd[d] = data[0]; sl[d] = (len == 1);
         waits = $urandom_range(0, 2);
         for (int w = 0; w <= waits; w++) begin
            mhr[d] = (w == waits) ? (oh | 4'($urandom)) : (4'($urandom) & ~oh);
            #1;
            chk("hdr_valid", 64'(mhv[d]), 64'(oh));
            chk("hdr_type", 64'(mty[d]), 64'(t));
            chk("hdr_dest", 64'(mdm[d]), 64'(dm));
            chk("hdr_src", 64'(msm[d]), 64'(sm));
            chk("hdr_s_tready", 64'(sr[d]), 64'd0);
            chk("hdr_m_tvalid", 64'(mv[d]), 64'd0);
            chk("hdr_hdr_ready", 64'(hr[d]), 64'd0);
            chk("hdr_busy", 64'(bz[d]), 64'd1);
            tick();
         end
         mhr[d] = 4'b0;
      end else begin
         #1;
         chk("drop_hdr_valid", 64'(mhv[d]), 64'd0);
         chk("drop_busy", 64'(bz[d]), 64'd1);
      end
      k = 0; cyc = 0;
      while (k < len && cyc < 200) begin
         v = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         sv[d] = v; sd[d] = data[k]; sl[d] = (k == len-1); su[d] = 1'($urandom);
         en[d] = 4'($urandom);
         case (mode)
            0:       mr[d] = 4'hF;
            1:       mr[d] = 4'($urandom);
            default: mr[d] = (cyc % 2 == 0) ? 4'hF : 4'h0;
         endcase
         #1;
         if (ch >= 0) begin
            chk("pl_m_tvalid", 64'(mv[d]), v ? 64'(oh) : 64'd0);
            chk("pl_s_tready", 64'(sr[d]), 64'(mr[d][ch]));
            chk("pl_tdata", 64'(md[d]), 64'(data[k]));
            chk("pl_tlast", 64'(ml[d]), 64'(k == len-1));
            chk("pl_tuser", 64'(mu[d]), 64'(su[d]));
            chk("pl_hdr_valid", 64'(mhv[d]), 64'd0);
            if (v && mr[d][ch]) k++;
         end else begin
            chk("drop_s_tready", 64'(sr[d]), 64'd1);
            chk("drop_m_tvalid", 64'(mv[d]), 64'd0);
            if (v) k++;
         end
         cyc++;
         tick();
      end
      chk("frame_timeout", 64'(cyc < 200), 64'd1);
      if (ch < 0 && mdc[d] < cmax) mdc[d]++;
      sv[d] = 1'b0; sl[d] = 1'b0; mr[d] = 4'h0;
      #1;
      chk("end_busy", 64'(bz[d]), 64'd0);
      chk("end_hdr_ready", 64'(hr[d]), 64'd1);
      chk("drop_count", 64'(get_dc(d)), 64'(mdc[d]));
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         hv[d] = 0; sv[d] = 0; sl[d] = 0; su[d] = 0; sd[d] = 0; ty[d] = 0;
         dmac[d] = 0; smac[d] = 0; mhr[d] = 0; mr[d] = 0; en[d] = 4'hF; mdc[d] = 0;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("rst_busy", 64'(bz[d]), 64'd0);
         chk("rst_hdr_valid", 64'(mhv[d]), 64'd0);
         chk("rst_m_tvalid", 64'(mv[d]), 64'd0);
         chk("rst_s_tready", 64'(sr[d]), 64'd0);
         chk("rst_type", 64'(mty[d]), 64'd0);
         chk("rst_drop_count", 64'(get_dc(d)), 64'd0);
      end
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("post_rst_hdr_ready", 64'(hr[0]), 64'd1);

      run_frame(0, 16'h0806, 4'hF, 5, 0);
      run_frame(0, 16'h1234, 4'hF, 3, 0);
      run_frame(1, 16'h1234, 4'hF, 4, 0);
      run_frame(0, 16'h0800, 4'hE, 2, 0);
      run_frame(0, 16'h0800, 4'hF, 4, 2);
      run_frame(0, 16'h88CC, 4'hF, 1, 0);
      run_frame(0, 16'h86DD, 4'h8, 1, 1);
      run_frame(1, 16'h0806, 4'h0, 2, 1);

      // Reset in the middle of a routed frame.
      hv[0] = 1'b1; ty[0] = 16'h0806; en[0] = 4'hF;
      tick();
      hv[0] = 1'b0; mhr[0] = 4'b0010;
      tick();
      mhr[0] = 4'b0; sv[0] = 1'b1; sd[0] = 8'hA5; sl[0] = 1'b0; mr[0] = 4'hF;
      #1;
      chk("mid_s_tready", 64'(sr[0]), 64'd1);
      chk("mid_m_tvalid", 64'(mv[0]), 64'h2);
      tick();
      sd[0] = 8'h5A;
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_m_tvalid", 64'(mv[0]), 64'd0);
      chk("async_rst_hdr_valid", 64'(mhv[0]), 64'd0);
      chk("async_rst_busy", 64'(bz[0]), 64'd0);
      chk("async_rst_s_tready", 64'(sr[0]), 64'd0);
      chk("async_rst_type", 64'(mty[0]), 64'd0);
      chk("async_rst_drop_count", 64'(get_dc(0)), 64'd0);
      mdc[0] = 0; mdc[1] = 0;
      tick();
      rst = 1'b0; sl[0] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("stall_s_tready", 64'(sr[0]), 64'd0);
         chk("stall_m_tvalid", 64'(mv[0]), 64'd0);
         chk("stall_hdr_ready", 64'(hr[0]), 64'd1);
         tick();
      end
      sv[0] = 1'b0; sl[0] = 1'b0; mr[0] = 4'h0;
      run_frame(0, 16'h0806, 4'hF, 3, 1);

      // Saturation of the narrow drop counter.
      for (int i = 0; i < 9; i++) run_frame(0, 16'hBEEF, 4'hF, 1, i % 2);
      chk("drop_count_saturated", 64'(get_dc(0)), 64'((1 << CW0) - 1));

      for (int i = 0; i < 60; i++)
         run_frame(int'($urandom_range(0, 1)), pick_type(), 4'($urandom),
                   int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
